// File: rtl/seq_div_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seq_div_if
// Purpose  : Request/result bundle for the iterative divider.
//            The master (ALU decode or testbench) drives the operands and the
//            start request. The slave (seq_div) returns the registered
//            quotient/remainder and its status flags.
// Signals  : start  - request, sampled by the divider only while idle
//            a      - dividend
//            b      - divisor
//            ctrl   - mode; only ctrl[1:0] is meaningful
//            lower  - quotient (LO)
//            higher - remainder (HI)
//            busy   - operation in flight
//            done   - one-cycle pulse when lower/higher/dbz update
//            dbz    - last result was a divide by zero
// Revision : 1.0 - initial release
// ============================================================================
interface seq_div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [4:0]       ctrl;
  logic [WIDTH-1:0] lower;
  logic [WIDTH-1:0] higher;
  logic             busy;
  logic             done;
  logic             dbz;

  modport master (
    output start, a, b, ctrl,
    input  lower, higher, busy, done, dbz
  );

  modport slave (
    input  start, a, b, ctrl,
    output lower, higher, busy, done, dbz
  );
endinterface
`default_nettype wire

// File: rtl/seq_div.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seq_div
// Purpose  : Iterative restoring divider. It resolves one quotient bit per
//            clock, MSB first, on operand magnitudes, then applies a sign
//            fix-up. The quotient is returned on lower and the remainder on
//            higher, following the LO/HI convention. Sign handling uses the
//            same ctrl[1:0] field as the shift-add multiplier:
//              00/01 signed / signed, 10 signed / unsigned,
//              11 unsigned / unsigned.
//            Latency is 33 clocks from the accepted start to the result, or
//            1 clock for a divide by zero.
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset
//            bus   - seq_div_if slave (start/a/b/ctrl in,
//                    lower/higher/busy/done/dbz out)
// Revision : 1.0 - initial release
// ============================================================================
module seq_div #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_div_if.slave bus
);

  // The iteration counter is 5 bits, so the datapath is fixed at 32 bits.
  localparam logic [4:0] c_last_iter = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t           r_state;
  logic [4:0]       r_cnt;
  // r_dvd starts as |dividend|. Its MSB feeds the partial remainder each
  // cycle while the new quotient bit enters at the LSB, so after 32 cycles
  // the register holds the unsigned quotient.
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  // The kept partial remainder is always below the divisor, so WIDTH bits
  // are enough to store it. Only the shifted trial value needs WIDTH+1 bits.
  logic [WIDTH-1:0] r_rem;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_zero;

  logic [WIDTH-1:0] r_lower;
  logic [WIDTH-1:0] r_higher;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;

  // --------------------------------------------------------------------------
  // Operand decode (only used on the accepting cycle)
  // --------------------------------------------------------------------------
  logic             w_a_signed;
  logic             w_b_signed;
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_b_zero;
  logic             w_unused_ctrl;

  assign w_a_signed    = (bus.ctrl[1:0] != 2'b11);
  assign w_b_signed    = ~bus.ctrl[1];
  assign w_sa          = w_a_signed & bus.a[WIDTH-1];
  assign w_sb          = w_b_signed & bus.b[WIDTH-1];
  assign w_a_mag       = w_sa ? (~bus.a + 1'b1) : bus.a;
  assign w_b_mag       = w_sb ? (~bus.b + 1'b1) : bus.b;
  assign w_b_zero      = (bus.b == '0);
  // ctrl[4:2] belongs to the shared ALU field but has no meaning here.
  assign w_unused_ctrl = ^bus.ctrl[4:2];

  // --------------------------------------------------------------------------
  // One restoring step
  // --------------------------------------------------------------------------
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_keep;

  assign w_shift = {r_rem, r_dvd[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};
  // The trial result is non-negative exactly when its top bit is clear. A
  // successful subtraction leaves a value below the divisor, and a failed
  // one wraps into [-2^WIDTH, 0), so the top bit tells the two cases apart.
  assign w_keep  = ~w_trial[WIDTH];

  // --------------------------------------------------------------------------
  // Sign fix-up
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;

  // 0x80000000 / -1 falls out of the plain negation: -(0x80000000) wraps to
  // itself, which is the intended overflow result.
  assign w_quot = r_qneg ? (~r_dvd + 1'b1) : r_dvd;
  // On a divide by zero r_rem holds the raw dividend and r_rneg is clear, so
  // higher returns the dividend unmodified.
  assign w_rem  = r_rneg ? (~r_rem + 1'b1) : r_rem;

  // --------------------------------------------------------------------------
  // Controller and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_zero   <= 1'b0;
      r_lower  <= '0;
      r_higher <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_dvs  <= w_b_mag;
            r_qneg <= w_sa ^ w_sb;
            if (w_b_zero) begin
              // No iteration is needed. Park the raw dividend where the
              // fix-up stage picks up the remainder.
              r_zero  <= 1'b1;
              r_dvd   <= '0;
              r_rem   <= bus.a;
              r_rneg  <= 1'b0;
              r_state <= S_FIX;
            end else begin
              r_zero  <= 1'b0;
              r_dvd   <= w_a_mag;
              r_rem   <= '0;
              r_rneg  <= w_sa;
              r_state <= S_RUN;
            end
          end
        end

        S_RUN: begin
          r_dvd <= {r_dvd[WIDTH-2:0], w_keep};
          if (w_keep) begin
            r_rem <= w_trial[WIDTH-1:0];
          end else begin
            // Restore. The shifted value is below the divisor here, so its
            // top bit is zero and can be dropped.
            r_rem <= w_shift[WIDTH-1:0];
          end
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == c_last_iter) begin
            r_state <= S_FIX;
          end
        end

        S_FIX: begin
          r_lower  <= r_zero ? '1 : w_quot;
          r_higher <= w_rem;
          r_dbz    <= r_zero;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.lower  = r_lower;
  assign bus.higher = r_higher;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.dbz    = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_div.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_seq_div
// Purpose  : Self-checking bench for seq_div. A table of operand/result
//            records is driven through the divider. Expected results are
//            queued when start is driven and compared when done pulses, along
//            with the cycle on which done arrives. Hand-written sequences
//            cover the busy window, start while busy, back-to-back starts and
//            reset during an operation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_div;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  seq_div_if #(.WIDTH(32)) bus ();

  seq_div #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  ctrl;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
  } vec_t;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
    int          due;
  } exp_t;

  localparam int NVEC = 19;

  vec_t tbl[NVEC];
  exp_t sb[$];
  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_done: got done=1 expected no result pending (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("lower", bus.lower, e.lo);
        check("higher", bus.higher, e.hi);
        check("dbz", {31'd0, bus.dbz}, {31'd0, e.dbz});
        check("done_cycle", 32'(cyc), 32'(e.due));
        check("busy_in_done_cycle", {31'd0, bus.busy}, 32'd0);
        check("done_single_cycle", {31'd0, prev_done}, 32'd0);
      end
    end
    prev_done <= bus.done;
  end

  // Called just after a negedge. Drives start for one edge (E0), queues the
  // expectation, then scrambles the operands to prove they were captured.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] ctrl,
                       input logic [31:0] lo, input logic [31:0] hi, input logic dbz);
    exp_t e;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.ctrl  = ctrl;
    e.lo  = lo;
    e.hi  = hi;
    e.dbz = dbz;
    e.due = cyc + 1 + ((b == 32'd0) ? 1 : 33);
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.ctrl  = 5'($urandom);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d results pending expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int dn;

    tbl[0]  = '{32'd100,      32'd7,        5'b00011, 32'd14,       32'd2,        1'b0};
    tbl[1]  = '{32'hFFFFFF9C, 32'd7,        5'b00000, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
    tbl[2]  = '{32'd100,      32'hFFFFFFF9, 5'b00000, 32'hFFFFFFF2, 32'd2,        1'b0};
    tbl[3]  = '{32'hFFFFFFFF, 32'd2,        5'b00011, 32'h7FFFFFFF, 32'd1,        1'b0};
    tbl[4]  = '{32'hFFFFFFFF, 32'd2,        5'b00000, 32'd0,        32'hFFFFFFFF, 1'b0};
    tbl[5]  = '{32'hFFFFFFFF, 32'd2,        5'b00010, 32'd0,        32'hFFFFFFFF, 1'b0};
    tbl[6]  = '{32'h00001234, 32'd0,        5'b00000, 32'hFFFFFFFF, 32'h00001234, 1'b1};
    tbl[7]  = '{32'h80000000, 32'hFFFFFFFF, 5'b00000, 32'h80000000, 32'd0,        1'b0};
    tbl[8]  = '{32'hDEADBEEF, 32'd0,        5'b00011, 32'hFFFFFFFF, 32'hDEADBEEF, 1'b1};
    tbl[9]  = '{32'h80000000, 32'hFFFFFFFF, 5'b00011, 32'd0,        32'h80000000, 1'b0};
    tbl[10] = '{32'hFFFFFFF9, 32'hFFFFFFFE, 5'b00001, 32'd3,        32'hFFFFFFFF, 1'b0};
    tbl[11] = '{32'hFFFFFF9C, 32'd7,        5'b11101, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0};
    tbl[12] = '{32'hFFFFFFFB, 32'hFFFFFFFF, 5'b00010, 32'd0,        32'hFFFFFFFB, 1'b0};
    tbl[13] = '{32'hFFFFFFFF, 32'd1,        5'b00011, 32'hFFFFFFFF, 32'd0,        1'b0};
    tbl[14] = '{32'd0,        32'd5,        5'b00000, 32'd0,        32'd0,        1'b0};
    tbl[15] = '{32'd7,        32'd100,      5'b00011, 32'd0,        32'd7,        1'b0};
    tbl[16] = '{32'd100,      32'd7,        5'b00010, 32'd14,       32'd2,        1'b0};
    tbl[17] = '{32'h12345678, 32'h00001000, 5'b00011, 32'h00012345, 32'h00000678, 1'b0};
    tbl[18] = '{32'hFFFFFFF0, 32'd16,       5'b10111, 32'h0FFFFFFF, 32'd0,        1'b0};

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.ctrl  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_lower", bus.lower, 32'd0);
    check("rst_higher", bus.higher, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_dbz", {31'd0, bus.dbz}, 32'd0);

    // Busy window on unsigned 100 / 7
    issue(32'd100, 32'd7, 5'b00011, 32'd14, 32'd2, 1'b0);
    n  = 0;
    dn = 0;
    while (bus.done !== 1'b1 && dn < 100) begin
      if (bus.busy === 1'b1) n++;
      @(negedge clk);
      dn++;
    end
    check("busy_cycles", 32'(n), 32'd33);
    wait_drain();

    // Table sweep
    for (int i = 0; i < NVEC; i++) begin
      issue(tbl[i].a, tbl[i].b, tbl[i].ctrl, tbl[i].lo, tbl[i].hi, tbl[i].dbz);
      wait_drain();
    end

    // Start while busy: a second request at E10 must be ignored
    issue(32'd100, 32'd7, 5'b00011, 32'd14, 32'd2, 1'b0);
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'd5;
    bus.b     = 32'd1;
    bus.ctrl  = 5'b00011;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain();
    repeat (40) @(negedge clk);

    // Back-to-back: start in the done cycle
    issue(32'hFFFFFF9C, 32'd7, 5'b00000, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
    n = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_done_seen", {31'd0, bus.done}, 32'd1);
    issue(32'd1000, 32'd3, 5'b00011, 32'd333, 32'd1, 1'b0);
    wait_drain();

    // Reset in the middle of an operation
    issue(32'd77, 32'd5, 5'b00011, 32'd15, 32'd2, 1'b0);
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_lower", bus.lower, 32'd0);
    check("midrst_higher", bus.higher, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    check("midrst_dbz", {31'd0, bus.dbz}, 32'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
    end
    check("no_done_after_abort", 32'(dn), 32'd0);
    issue(32'd9, 32'd3, 5'b00011, 32'd3, 32'd0, 1'b0);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
